alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `alu32` datapath between up to four requesters, such as the decode/execute path and an address-generation or branch-compare unit. It accepts one operation per cycle over per-requester valid/ready handshakes and drives the shared `alu32` combinationally. Each result is registered into a one-deep response slot, tagged with the index of the requester that issued it. Downstream backpressure is honoured without losing or duplicating an operation.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu32.sv | 28 ++
 rtl/alu_share_arb.sv | 118 +++++++++++
 tb/tb_alu_share_arb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - alu32 op codes, op type, legality check and response slot state
package alu_pkg;

  typedef logic [5:0] alu_op_t;

  localparam alu_op_t OP_ADDI  = 6'd0;
  localparam alu_op_t OP_SLTI  = 6'd1;
  localparam alu_op_t OP_SLTIU = 6'd2;
  localparam alu_op_t OP_XORI  = 6'd3;
  localparam alu_op_t OP_ORI   = 6'd4;
  localparam alu_op_t OP_ANDI  = 6'd5;
  localparam alu_op_t OP_SLLI  = 6'd6;
  localparam alu_op_t OP_SRLI  = 6'd7;
  localparam alu_op_t OP_SRAI  = 6'd8;
  localparam alu_op_t OP_ADD   = 6'd9;
  localparam alu_op_t OP_SUB   = 6'd10;
  localparam alu_op_t OP_SLL   = 6'd11;
  localparam alu_op_t OP_SLT   = 6'd12;
  localparam alu_op_t OP_SLTU  = 6'd13;
  localparam alu_op_t OP_XOR   = 6'd14;
  localparam alu_op_t OP_SRL   = 6'd15;
  localparam alu_op_t OP_SRA   = 6'd16;
  localparam alu_op_t OP_OR    = 6'd17;
  localparam alu_op_t OP_AND   = 6'd18;
  localparam alu_op_t OP_LAST  = OP_AND;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

  function automatic logic op_legal(input alu_op_t op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu32.sv
// rtl/alu32.sv - combinational 32-bit ALU; immediate forms take the immediate on i_b
module alu32
  import alu_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADDI, OP_ADD: o_y = i_a + i_b;
      OP_SUB:          o_y = i_a - i_b;
      OP_SLTI, OP_SLT: o_y = {31'd0, $signed(i_a) < $signed(i_b)};
      OP_SLTIU, OP_SLTU: o_y = {31'd0, i_a < i_b};
      OP_XORI, OP_XOR: o_y = i_a ^ i_b;
      OP_ORI, OP_OR:   o_y = i_a | i_b;
      OP_ANDI, OP_AND: o_y = i_a & i_b;
      OP_SLLI, OP_SLL: o_y = i_a << i_b[4:0];
      OP_SRLI, OP_SRL: o_y = i_a >> i_b[4:0];
      OP_SRAI, OP_SRA: o_y = $signed(i_a) >>> i_b[4:0];
      default:         o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sharing of one alu32 among NREQ requesters
// with a one-deep tagged response slot.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [6*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [1:0]           rsp_src,
  output logic                 rsp_err
);

  slot_t       r_slot;
  logic [31:0] r_data;
  logic [1:0]  r_src;
  logic        r_err;
  logic [1:0]  r_ptr;

  logic [3:0]  w_valid4;
  logic [3:0]  w_ready4;
  logic [2:0]  w_cand;
  logic [1:0]  w_gnt;
  logic [1:0]  w_sel;
  logic        w_any;
  logic        w_slot_free;
  logic        w_xfer;
  logic        w_legal;
  alu_op_t     w_op;
  alu_op_t     w_alu_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_y;

  assign w_valid4    = 4'(req_valid);
  assign w_slot_free = (r_slot == SLOT_EMPTY) || rsp_ready;

  // First valid requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = 2'd0;
    w_cand = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + 3'(k);
      if (w_cand >= 3'(NREQ)) w_cand = w_cand - 3'(NREQ);
      if (!w_any && w_valid4[w_cand[1:0]]) begin
        w_any = 1'b1;
        w_gnt = w_cand[1:0];
      end
    end
  end

  always_comb begin
    w_ready4 = 4'd0;
    if (rst_n && w_slot_free && w_any) w_ready4[w_gnt] = 1'b1;
  end

  assign req_ready = w_ready4[NREQ-1:0];
  assign w_xfer    = (w_ready4 != 4'd0);

  // Idle cycles steer requester 0 into the ALU so its inputs stay defined.
  assign w_sel = w_xfer ? w_gnt : 2'd0;

  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_sel == 2'(k)) begin
        w_op = req_op[6*k +: 6];
        w_a  = req_a[32*k +: 32];
        w_b  = req_b[32*k +: 32];
      end
    end
  end

  assign w_legal  = op_legal(w_op);
  assign w_alu_op = w_legal ? w_op : OP_ADDI;

  alu32 u_alu32 (
    .i_op (w_alu_op),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_y  (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= SLOT_EMPTY;
      r_data <= '0;
      r_src  <= '0;
      r_err  <= 1'b0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_slot <= SLOT_FULL;
      r_data <= w_legal ? w_y : 32'd0;
      r_src  <= w_gnt;
      r_err  <= ~w_legal;
      r_ptr  <= (w_gnt == 2'(NREQ-1)) ? 2'd0 : w_gnt + 2'd1;
    end else if (rsp_ready) begin
      r_slot <= SLOT_EMPTY;
    end
  end

  assign rsp_valid = (r_slot == SLOT_FULL);
  assign rsp_data  = r_data;
  assign rsp_src   = r_src;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed and randomised checks of alu_share_arb with NREQ=3
module tb_alu_share_arb;

  localparam int NREQ = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [6*NREQ-1:0]   req_op;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [1:0]          rsp_src;
  logic                rsp_err;

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_src   (rsp_src),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0, 9:   return a + b;
      10:     return a - b;
      1, 12:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      2, 13:  return (a < b) ? 32'd1 : 32'd0;
      3, 14:  return a ^ b;
      4, 17:  return a | b;
      5, 18:  return a & b;
      6, 11:  return a << b[4:0];
      7, 15:  return a >> b[4:0];
      8, 16:  return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: slot contents and rotation pointer as plain integers.
  int              m_ptr = 0;
  bit              m_valid = 0;
  logic [31:0]     m_data = '0;
  int              m_src = 0;
  bit              m_err = 0;
  int              m_g;
  int              m_op;
  logic [NREQ-1:0] m_rdy;
  logic [NREQ-1:0] m_acc = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_err = 0; m_acc = '0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_src", 32'(rsp_src), 32'(m_src));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      m_g = -1;
      if (!m_valid || rsp_ready)
        for (int k = 0; k < NREQ; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
      m_rdy = '0;
      if (m_g >= 0) m_rdy[m_g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(m_rdy));
      m_acc = m_rdy;
      if (m_g >= 0) begin
        m_op    = int'(req_op[6*m_g +: 6]);
        m_err   = (m_op > 18);
        m_data  = m_err ? 32'd0 : ref_alu(m_op, req_a[32*m_g +: 32], req_b[32*m_g +: 32]);
        m_src   = m_g;
        m_valid = 1;
        m_ptr   = (m_g + 1) % NREQ;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
    req_op[6*i +: 6]  = 6'(op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick;
    tick;
    // Round-robin from reset: all three valid, continuous drain.
    set_req(0, 9, 32'd1, 32'd1);
    set_req(1, 14, 32'hFF00FF00, 32'h0F0F0F0F);
    set_req(2, 18, 32'h12345678, 32'h0000FFFF);
    req_valid = 3'b111;
    #1;
    chk("lit_reset_ready", 32'(req_ready), 32'd0);
    chk("lit_reset_valid", 32'(rsp_valid), 32'd0);
    tick;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("lit_first_grant", 32'(req_ready), 32'b001);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("lit_rr_src", 32'(rsp_src), 32'(i % 3));
      chk("lit_rr_valid", 32'(rsp_valid), 32'd1);
    end
    // Single SUB from requester 1.
    req_valid = 3'b010;
    set_req(1, 10, 32'd5, 32'd7);
    tick;
    chk("lit_sub_data", rsp_data, 32'hFFFFFFFE);
    chk("lit_sub_src", 32'(rsp_src), 32'd1);
    chk("lit_sub_err", 32'(rsp_err), 32'd0);
    req_valid = '0;
    tick;
    chk("lit_drained", 32'(rsp_valid), 32'd0);
    // Backpressure with SRA, then same-cycle drain and fill.
    rsp_ready = 1'b0;
    req_valid = 3'b001;
    set_req(0, 8, 32'h80000000, 32'd4);
    tick;
    set_req(0, 9, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("lit_bp_data", rsp_data, 32'hF8000000);
      chk("lit_bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("lit_bp_refill_ready", 32'(req_ready), 32'b001);
    tick;
    chk("lit_bp_new_data", rsp_data, 32'd3);
    // Mid-transfer asynchronous reset, then illegal op from requester 0.
    rsp_ready = 1'b0;
    set_req(0, 5, 32'hF0F0F0F0, 32'hFFFF0000);
    tick;
    #1;
    rst_n = 1'b0;
    #1;
    chk("lit_async_valid", 32'(rsp_valid), 32'd0);
    chk("lit_async_data", rsp_data, 32'd0);
    chk("lit_async_src", 32'(rsp_src), 32'd0);
    chk("lit_async_ready", 32'(req_ready), 32'd0);
    set_req(0, 19, 32'h1234, 32'h5678);
    tick;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("lit_post_reset_grant", 32'(req_ready), 32'b001);
    tick;
    chk("lit_illegal_err", 32'(rsp_err), 32'd1);
    chk("lit_illegal_data", rsp_data, 32'd0);
    req_valid = 3'b111;
    #1;
    chk("lit_illegal_rotates", 32'(req_ready), 32'b010);
    // Signed vs unsigned compare.
    req_valid = 3'b100;
    set_req(2, 1, 32'hFFFFFFFF, 32'd1);
    tick;
    chk("lit_slti", rsp_data, 32'd1);
    req_valid = 3'b010;
    set_req(1, 2, 32'hFFFFFFFF, 32'd1);
    tick;
    chk("lit_sltiu", rsp_data, 32'd0);
    // Random traffic, holding each payload until the model sees it accepted.
    req_valid = '0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || m_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(i, int'($urandom_range(0, 21)), $urandom,
                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
